// File: rtl/uart_mmio_if.sv
// Core data-port view of the UART MMIO block: strobes, address and data from the
// core, and the combinational load data and decode hit returned to it.
interface uart_mmio_if;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] data_addr;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        mmio_hit;

  modport master (
    output mem_write,
    output mem_read,
    output data_addr,
    output write_data,
    input  read_data,
    input  mmio_hit
  );

  modport slave (
    input  mem_write,
    input  mem_read,
    input  data_addr,
    input  write_data,
    output read_data,
    output mmio_hit
  );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped UART responder: stores to the data register fill a TX FIFO that
// drains one paced character per pop to the console; loads poll the RX side.
module uart_mmio #(
  parameter int          TX_DEPTH  = 16,
  parameter int          TX_GAP    = 0,
  parameter logic [63:0] ADDR_DATA = 64'h0000_0000_1000_0000,
  parameter logic [63:0] ADDR_LSR  = 64'h0000_0000_1000_0005
) (
  input  logic       clk,
  input  logic       rst,
  uart_mmio_if.slave bus,
  output logic       uart_out_valid,
  output logic [7:0] uart_out_ch,
  output logic       uart_in_valid,
  input  logic [7:0] uart_in_ch,
  output logic       tx_overflow
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = $clog2(TX_GAP + 2);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TX_DEPTH);
  localparam logic [GAP_W-1:0] GAP_C   = GAP_W'(TX_GAP);

  logic [7:0]       fifo_q [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_ch_q, out_ch_d;
  logic             ovf_q, ovf_d;

  logic        hit_data_s;
  logic        hit_lsr_s;
  logic        push_req_s;
  logic        pop_s;
  logic        push_s;
  logic        drop_s;
  logic [7:0]  lsr_s;
  logic [63:0] read_data_s;
  logic        unused_wdata_s;

  assign hit_data_s     = (bus.data_addr == ADDR_DATA);
  assign hit_lsr_s      = (bus.data_addr == ADDR_LSR);
  assign bus.mmio_hit   = hit_data_s | hit_lsr_s;
  assign unused_wdata_s = ^bus.write_data[63:8];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_req_s = bus.mem_write & hit_data_s;
  assign pop_s      = (count_q != {CNT_W{1'b0}}) & (gap_q == {GAP_W{1'b0}});
  assign push_s     = push_req_s & ((count_q < DEPTH_C) | pop_s);
  assign drop_s     = push_req_s & ~push_s;

  assign lsr_s = {ovf_q,
                  (count_q == {CNT_W{1'b0}}) & ~out_valid_q,
                  (count_q < DEPTH_C),
                  4'b0000,
                  1'b1};

  // FIFO pointers, occupancy, pacing and output next-state
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    gap_d       = gap_q;
    out_valid_d = pop_s;
    out_ch_d    = out_ch_q;
    ovf_d       = ovf_q | drop_s;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      out_ch_d = fifo_q[rd_ptr_q];
      gap_d    = GAP_C;
    end else if (gap_q != {GAP_W{1'b0}}) begin
      gap_d = gap_q - {{(GAP_W-1){1'b0}}, 1'b1};
    end else begin
      gap_d = gap_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      gap_q       <= {GAP_W{1'b0}};
      out_valid_q <= 1'b0;
      out_ch_q    <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      ovf_q       <= ovf_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TX_DEPTH; i++) begin
        fifo_q[i] <= 8'h00;
      end
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= bus.write_data[7:0];
    end else begin
      fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
    end
  end

  // Load data: RX character passes straight through, 8'hFF included
  always_comb begin
    read_data_s = 64'h0;
    if (bus.mem_read && hit_data_s) begin
      read_data_s = {56'h0, uart_in_ch};
    end else if (bus.mem_read && hit_lsr_s) begin
      read_data_s = {56'h0, lsr_s};
    end else begin
      read_data_s = 64'h0;
    end
  end

  assign bus.read_data  = read_data_s;
  assign uart_in_valid  = bus.mem_read & hit_data_s;
  assign uart_out_valid = out_valid_q;
  assign uart_out_ch    = out_ch_q;
  assign tx_overflow    = ovf_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: three instances (gap 0, gap 3, gap 7 / depth 4)
// share one driven bus, selected per test; a monitor checks every output pulse.
module tb_uart_mmio;
  localparam logic [63:0] A_DATA = 64'h0000_0000_1000_0000;
  localparam logic [63:0] A_LSR  = 64'h0000_0000_1000_0005;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        mem_write = 1'b0;
  logic        mem_read  = 1'b0;
  logic [63:0] addr      = 64'h0;
  logic [63:0] wdata     = 64'h0;
  logic [7:0]  in_ch     = 8'hFF;
  int          sel       = 0;

  uart_mmio_if if0 ();
  uart_mmio_if if1 ();
  uart_mmio_if if2 ();

  assign if0.mem_write  = mem_write & (sel == 0);
  assign if0.mem_read   = mem_read & (sel == 0);
  assign if0.data_addr  = addr;
  assign if0.write_data = wdata;
  assign if1.mem_write  = mem_write & (sel == 1);
  assign if1.mem_read   = mem_read & (sel == 1);
  assign if1.data_addr  = addr;
  assign if1.write_data = wdata;
  assign if2.mem_write  = mem_write & (sel == 2);
  assign if2.mem_read   = mem_read & (sel == 2);
  assign if2.data_addr  = addr;
  assign if2.write_data = wdata;

  logic [2:0]      ov;
  logic [2:0][7:0] oc;
  logic [2:0]      iv;
  logic [2:0]      ovf;
  logic [63:0]     rdata;
  logic            hit;

  assign rdata = (sel == 0) ? if0.read_data : (sel == 1) ? if1.read_data : if2.read_data;
  assign hit   = (sel == 0) ? if0.mmio_hit  : (sel == 1) ? if1.mmio_hit  : if2.mmio_hit;

  uart_mmio #(.TX_DEPTH(16), .TX_GAP(0)) u_gap0 (
    .clk(clk), .rst(rst), .bus(if0),
    .uart_out_valid(ov[0]), .uart_out_ch(oc[0]),
    .uart_in_valid(iv[0]), .uart_in_ch(in_ch), .tx_overflow(ovf[0])
  );
  uart_mmio #(.TX_DEPTH(16), .TX_GAP(3)) u_gap3 (
    .clk(clk), .rst(rst), .bus(if1),
    .uart_out_valid(ov[1]), .uart_out_ch(oc[1]),
    .uart_in_valid(iv[1]), .uart_in_ch(in_ch), .tx_overflow(ovf[1])
  );
  uart_mmio #(.TX_DEPTH(4), .TX_GAP(7)) u_gap7 (
    .clk(clk), .rst(rst), .bus(if2),
    .uart_out_valid(ov[2]), .uart_out_ch(oc[2]),
    .uart_in_valid(iv[2]), .uart_in_ch(in_ch), .tx_overflow(ovf[2])
  );

  int n_tests = 0;
  int n_fail  = 0;
  // Expected pulses per instance: {cycle[31:0], char[7:0]}
  logic [39:0] exp0[$];
  logic [39:0] exp1[$];
  logic [39:0] exp2[$];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic cmp_pulse(input int k, input logic [39:0] e, input logic [7:0] ch);
    n_tests++;
    if (e[7:0] !== ch || e[39:8] != 32'(cyc)) begin
      n_fail++;
      $display("FAIL pulse%0d: got ch %h at cycle %0d expected ch %h at cycle %0d",
               k, ch, cyc, e[7:0], e[39:8]);
    end
  endtask

  task automatic unexpected(input int k, input logic [7:0] ch);
    n_tests++;
    n_fail++;
    $display("FAIL pulse%0d: got ch %h at cycle %0d expected no pulse", k, ch, cyc);
  endtask

  task automatic monitor();
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (ov[0]) begin
        if (exp0.size() == 0) unexpected(0, oc[0]);
        else begin e = exp0.pop_front(); cmp_pulse(0, e, oc[0]); end
      end
      if (ov[1]) begin
        if (exp1.size() == 0) unexpected(1, oc[1]);
        else begin e = exp1.pop_front(); cmp_pulse(1, e, oc[1]); end
      end
      if (ov[2]) begin
        if (exp2.size() == 0) unexpected(2, oc[2]);
        else begin e = exp2.pop_front(); cmp_pulse(2, e, oc[2]); end
      end
    end
  endtask

  task automatic st(input logic [63:0] a, input logic [7:0] d);
    mem_write = 1'b1;
    addr      = a;
    wdata     = {56'hDE_ADBE_EF00_0000, d};
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [63:0] a, input logic [63:0] expv, input string name);
    mem_read = 1'b1;
    addr     = a;
    #1;
    check64(name, rdata, expv);
    mem_read = 1'b0;
    addr     = 64'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  int c;

  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    fork
      monitor();
    join_none

    // Reset state and idle LSR on every instance
    idle(10);
    check64("idle_valid", 64'(ov), 64'h0);
    check64("idle_ch", 64'(oc), 64'h0);
    check64("idle_ovf", 64'(ovf), 64'h0);
    sel = 0; rd(A_LSR, 64'h61, "idle_lsr0");
    sel = 1; rd(A_LSR, 64'h61, "idle_lsr1");
    sel = 2; rd(A_LSR, 64'h61, "idle_lsr2");

    // Gap 0: back-to-back pulses, first one 2 cycles after the store
    sel = 0;
    c = cyc;
    exp0.push_back({32'(c + 2), 8'h48});
    exp0.push_back({32'(c + 3), 8'h69});
    st(A_DATA, 8'h48);
    st(A_DATA, 8'h69);
    idle(4);
    rd(A_LSR, 64'h61, "gap0_lsr_done");

    // Gap 3: pulses 4 cycles apart; bit6 clear while the last pulse is up
    sel = 1;
    c = cyc;
    exp1.push_back({32'(c + 2), 8'h31});
    exp1.push_back({32'(c + 6), 8'h32});
    exp1.push_back({32'(c + 10), 8'h33});
    st(A_DATA, 8'h31);
    st(A_DATA, 8'h32);
    st(A_DATA, 8'h33);
    rd(A_LSR, 64'h21, "gap3_lsr_busy");
    wait_cyc(c + 10);
    rd(A_LSR, 64'h21, "gap3_lsr_lastpulse");
    idle(1);
    rd(A_LSR, 64'h61, "gap3_lsr_done");

    // Gap 7, depth 4: sixth byte dropped, overflow sticky, bit5 returns
    sel = 2;
    c = cyc;
    for (int k = 0; k < 5; k++) exp2.push_back({32'(c + 2 + 8 * k), 8'(8'hA0 + k)});
    for (int k = 0; k < 6; k++) st(A_DATA, 8'(8'hA0 + k));
    rd(A_LSR, 64'h81, "gap7_lsr_full");
    check64("gap7_ovf", 64'(ovf), 64'h4);
    wait_cyc(c + 10);
    rd(A_LSR, 64'hA1, "gap7_lsr_space");
    wait_cyc(c + 35);
    rd(A_LSR, 64'hE1, "gap7_lsr_empty");

    // RX polling: character and 8'hFF pass through, no FIFO effect
    sel = 0;
    in_ch = 8'h41; mem_read = 1'b1; addr = A_DATA; #1;
    check64("rx_valid_41", 64'(iv), 64'h1);
    check64("rx_data_41", rdata, 64'h41);
    check64("rx_hit", 64'(hit), 64'h1);
    @(negedge clk);
    in_ch = 8'hFF; #1;
    check64("rx_valid_ff", 64'(iv), 64'h1);
    check64("rx_data_ff", rdata, 64'hFF);
    mem_read = 1'b0; #1;
    check64("rx_valid_off", 64'(iv), 64'h0);
    check64("rx_data_off", rdata, 64'h0);
    idle(3);
    rd(A_LSR, 64'h61, "rx_lsr");

    // Decode: neighbouring address misses, LSR writes are ignored
    mem_write = 1'b1; addr = A_DATA + 64'h1; wdata = 64'h5A; #1;
    check64("decode_miss_hit", 64'(hit), 64'h0);
    @(negedge clk);
    mem_write = 1'b0;
    rd(A_DATA + 64'h1, 64'h0, "decode_miss_rd");
    mem_write = 1'b1; addr = A_LSR; wdata = 64'h5B; #1;
    check64("decode_lsr_hit", 64'(hit), 64'h1);
    @(negedge clk);
    mem_write = 1'b0;
    idle(5);
    rd(A_LSR, 64'h61, "decode_lsr");

    // Reset mid-drain with three bytes buffered
    sel = 2;
    c = cyc;
    exp2.push_back({32'(c + 2), 8'hC0});
    st(A_DATA, 8'hC0);
    st(A_DATA, 8'hC1);
    st(A_DATA, 8'hC2);
    st(A_DATA, 8'hC3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    check64("rst_valid", 64'(ov), 64'h0);
    check64("rst_ch", 64'(oc[2]), 64'h0);
    check64("rst_ovf", 64'(ovf), 64'h0);
    rd(A_LSR, 64'h61, "rst_lsr");

    idle(5);
    check64("q0_drained", 64'(exp0.size()), 64'h0);
    check64("q1_drained", 64'(exp1.size()), 64'h0);
    check64("q2_drained", 64'(exp2.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
